cl_dmem_ctrl: RTL and testbench

//  MEM-stage data-memory controller sitting directly downstream of the decode controller.

---
 rtl/cl_dmem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cl_dmem_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_dmem_ctrl.sv
// cl_dmem_ctrl: MEM-stage data-memory controller (one valid/yumi request per op).
// Ports: decoded op flags/addr/data in; dmem req/resp; stall, load result, error pulses out.
module cl_dmem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  is_mem_op_i,
  input  logic                  is_load_op_i,
  input  logic                  is_store_op_i,
  input  logic                  is_byte_op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  req_valid_o,
  input  logic                  req_yumi_i,
  output logic                  req_we_o,
  output logic [ADDR_WIDTH-3:0] req_addr_o,
  output logic [31:0]           req_wdata_o,
  output logic [3:0]            req_mask_o,
  input  logic                  resp_valid_i,
  input  logic [31:0]           resp_data_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [31:0]           load_data_o,
  output logic                  err_misalign_o,
  output logic                  err_timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } state_t;

  // Last WAIT_RESP cycle: the counter starts at 0 on entry.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic                  load_q, load_d;
  logic                  store_q, store_d;
  logic                  byte_q, byte_d;
  logic                  mis_q, mis_d;
  logic                  tmo_q, tmo_d;
  logic                  lok_q, lok_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [31:0]           ld_q, ld_d;

  logic                  start;
  logic                  misalign;
  logic [7:0]            lane;
  logic [31:0]           aligned;
  logic [31:0]           wdata;
  logic [3:0]            mask;

  assign start    = valid_i & is_mem_op_i;
  assign misalign = ~is_byte_op_i & (addr_i[1:0] != 2'b00);

  always_comb begin
    unique case (addr_q[1:0])
      2'd0: lane = resp_data_i[7:0];
      2'd1: lane = resp_data_i[15:8];
      2'd2: lane = resp_data_i[23:16];
      2'd3: lane = resp_data_i[31:24];
    endcase
    aligned = byte_q ? {24'b0, lane} : resp_data_i;
  end

  assign wdata = byte_q ? {4{sdata_q[7:0]}} : sdata_q;
  assign mask  = (store_q & byte_q) ? (4'b0001 << addr_q[1:0]) : 4'b1111;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    load_d         = load_q;
    store_d        = store_q;
    byte_d         = byte_q;
    mis_d          = mis_q;
    tmo_d          = tmo_q;
    lok_d          = lok_q;
    cnt_d          = cnt_q;
    ld_d           = ld_q;
    stall_o        = 1'b0;
    req_valid_o    = 1'b0;
    req_we_o       = 1'b0;
    req_addr_o     = '0;
    req_wdata_o    = '0;
    req_mask_o     = '0;
    load_valid_o   = 1'b0;
    load_data_o    = '0;
    err_misalign_o = 1'b0;
    err_timeout_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = start;
        if (start) begin
          addr_d  = addr_i;
          sdata_d = store_data_i;
          load_d  = is_load_op_i;
          store_d = is_store_op_i;
          byte_d  = is_byte_op_i;
          mis_d   = misalign;
          tmo_d   = 1'b0;
          lok_d   = 1'b0;
          ld_d    = '0;
          cnt_d   = '0;
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        stall_o     = 1'b1;
        req_valid_o = 1'b1;
        req_we_o    = store_q;
        req_addr_o  = addr_q[ADDR_WIDTH-1:2];
        req_wdata_o = wdata;
        req_mask_o  = mask;
        if (req_yumi_i) begin
          cnt_d = '0;
          if (!load_q) begin
            state_d = DONE;
          end else if (resp_valid_i) begin
            ld_d    = aligned;
            lok_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // A response in the final cycle still wins over the timeout.
        if (resp_valid_i) begin
          ld_d    = aligned;
          lok_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          ld_d    = '0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        load_valid_o   = lok_q;
        load_data_o    = ld_q;
        err_misalign_o = mis_q;
        err_timeout_o  = tmo_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      byte_q  <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
      lok_q   <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      store_q <= store_d;
      byte_q  <= byte_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      lok_q   <= lok_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_cl_dmem_ctrl.sv
// tb_cl_dmem_ctrl: directed bench for cl_dmem_ctrl with an expectation queue.
// Ports: none (top-level bench).
module tb_cl_dmem_ctrl;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, is_mem_op_i, is_load_op_i;
  logic          is_store_op_i, is_byte_op_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   store_data_i;
  logic          req_valid_o, req_yumi_i, req_we_o;
  logic [AW-3:0] req_addr_o;
  logic [31:0]   req_wdata_o;
  logic [3:0]    req_mask_o;
  logic          resp_valid_i;
  logic [31:0]   resp_data_i;
  logic          stall_o, load_valid_o;
  logic [31:0]   load_data_o;
  logic          err_misalign_o, err_timeout_o;

  always #5 clk = ~clk;

  cl_dmem_ctrl #(
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .is_mem_op_i   (is_mem_op_i),
    .is_load_op_i  (is_load_op_i),
    .is_store_op_i (is_store_op_i),
    .is_byte_op_i  (is_byte_op_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .req_valid_o   (req_valid_o),
    .req_yumi_i    (req_yumi_i),
    .req_we_o      (req_we_o),
    .req_addr_o    (req_addr_o),
    .req_wdata_o   (req_wdata_o),
    .req_mask_o    (req_mask_o),
    .resp_valid_i  (resp_valid_i),
    .resp_data_i   (resp_data_i),
    .stall_o       (stall_o),
    .load_valid_o  (load_valid_o),
    .load_data_o   (load_data_o),
    .err_misalign_o(err_misalign_o),
    .err_timeout_o (err_timeout_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        mis;
    logic        to;
    int          stalls;
    int          nreq;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && valid_i)
      chk("ld_st_excl", {31'b0, is_load_op_i & is_store_op_i}, 32'h0);
  end

  task automatic idle_inputs();
    valid_i       = 1'b0;
    is_mem_op_i   = 1'b0;
    is_load_op_i  = 1'b0;
    is_store_op_i = 1'b0;
    is_byte_op_i  = 1'b0;
    addr_i        = '0;
    store_data_i  = '0;
    req_yumi_i    = 1'b0;
    resp_valid_i  = 1'b0;
    resp_data_i   = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, {31'b0, stall_o}, 32'h0);
    chk({tag, ".req_valid"}, {31'b0, req_valid_o}, 32'h0);
    chk({tag, ".load_valid"}, {31'b0, load_valid_o}, 32'h0);
    chk({tag, ".load_data"}, load_data_o, 32'h0);
    chk({tag, ".errs"}, {30'b0, err_misalign_o, err_timeout_o}, 32'h0);
    chk({tag, ".req_fields"},
        {req_we_o, req_mask_o, 27'b0} | req_addr_o | req_wdata_o, 32'h0);
  endtask

  // yd: REQ cycles before yumi; rd: cycles after yumi until response
  // (0 = same cycle as yumi, negative = never).
  task automatic run_op(input string tag, input logic ld, input logic bt,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int yd, input int rd, input logic [31:0] rdata);
    req_t  er, gr;
    done_t ed;
    logic  mis, got, done;
    int    wait_n, sh, stalls, nreq, reqc, since, stray;
    mis      = !bt && (a[1:0] != 2'b00);
    er.we    = !ld;
    er.addr  = {2'b00, a[31:2]};
    er.mask  = (ld || !bt) ? 4'hF : (4'b0001 << a[1:0]);
    er.wdata = bt ? {4{sd[7:0]}} : sd;
    if (!mis) req_q.push_back(er);
    got = ld && !mis && rd >= 0 && rd <= TO;
    if (!ld || mis) wait_n = 0;
    else if (got) wait_n = rd;
    else wait_n = TO;
    sh        = 8 * int'(a[1:0]);
    ed.lv     = got;
    ed.ld     = !got ? 32'h0 : (bt ? ((rdata >> sh) & 32'hFF) : rdata);
    ed.mis    = mis;
    ed.to     = ld && !mis && !got;
    ed.stalls = mis ? 1 : 2 + yd + wait_n;
    ed.nreq   = mis ? 0 : 1;
    done_q.push_back(ed);

    valid_i       = 1'b1;
    is_mem_op_i   = 1'b1;
    is_load_op_i  = ld;
    is_store_op_i = !ld;
    is_byte_op_i  = bt;
    addr_i        = a;
    store_data_i  = ld ? $urandom : sd;
    stalls = 0; nreq = 0; reqc = 0; since = -1; stray = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        valid_i     = 1'b0;
        is_mem_op_i = 1'b0;
      end
      if (since >= 0) since++;
      req_yumi_i = req_valid_o && (reqc == yd);
      if (req_yumi_i) since = 0;
      resp_valid_i = ld && since >= 0 && since == rd;
      resp_data_i  = resp_valid_i ? rdata : $urandom;
      @(negedge clk);
      if (c > 0 && !stall_o) begin
        done = 1'b1;
        ed = done_q.pop_front();
        chk({tag, ".load_valid"}, {31'b0, load_valid_o}, {31'b0, ed.lv});
        chk({tag, ".load_data"}, load_data_o, ed.ld);
        chk({tag, ".err_misalign"}, {31'b0, err_misalign_o}, {31'b0, ed.mis});
        chk({tag, ".err_timeout"}, {31'b0, err_timeout_o}, {31'b0, ed.to});
        chk({tag, ".stall_cycles"}, stalls, ed.stalls);
        chk({tag, ".requests"}, nreq, ed.nreq);
        chk({tag, ".stray_pulses"}, stray, 0);
        chk({tag, ".done_req_valid"}, {31'b0, req_valid_o}, 32'h0);
      end else begin
        stalls += int'(stall_o);
        if (load_valid_o || err_misalign_o || err_timeout_o) stray++;
        if (req_valid_o) reqc++;
        if (req_valid_o && req_yumi_i) begin
          nreq++;
          if (req_q.size() == 0) begin
            chk({tag, ".unexpected_req"}, 32'h1, 32'h0);
          end else begin
            gr = req_q.pop_front();
            chk({tag, ".we"}, {31'b0, req_we_o}, {31'b0, gr.we});
            chk({tag, ".addr"}, {2'b00, req_addr_o}, gr.addr);
            chk({tag, ".mask"}, {28'b0, req_mask_o}, {28'b0, gr.mask});
            if (gr.we) chk({tag, ".wdata"}, req_wdata_o, gr.wdata);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk({tag, ".retired"}, 32'h0, 32'h1);
      void'(done_q.pop_front());
    end
    req_q.delete();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset = 1'b0;

    // Non-memory instruction: no stall, no request.
    valid_i = 1'b1;
    @(negedge clk);
    chk("nonmem.stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("nonmem.req_valid", {31'b0, req_valid_o}, 32'h0);
    idle_inputs();

    run_op("sw",       1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1, -1, 32'h0);
    run_op("lbu_203",  1'b1, 1'b1, 32'h203, 32'h0, 0, 1, 32'hAABBCCDD);
    run_op("sb_11",    1'b0, 1'b1, 32'h11, 32'h1234567F, 0, -1, 32'h0);
    run_op("lw_mis",   1'b1, 1'b0, 32'h102, 32'h0, 0, -1, 32'h0);
    run_op("lw_tmo",   1'b1, 1'b0, 32'h400, 32'h0, 0, -1, 32'h0);
    run_op("lw_same",  1'b1, 1'b0, 32'h104, 32'h0, 2, 0, 32'h13579BDF);
    run_op("lw_race",  1'b1, 1'b0, 32'h108, 32'h0, 0, TO, 32'hCAFEF00D);
    run_op("lw_late",  1'b1, 1'b0, 32'h10C, 32'h0, 0, TO + 1, 32'h11111111);
    run_op("sw_mis",   1'b0, 1'b0, 32'h1, 32'h55AA55AA, 0, -1, 32'h0);
    run_op("lbu_0",    1'b1, 1'b1, 32'h200, 32'h0, 1, 2, 32'h01020384);
    run_op("lbu_1",    1'b1, 1'b1, 32'h201, 32'h0, 0, 0, 32'h0102E304);
    run_op("sb_13",    1'b0, 1'b1, 32'hFFFFFFF3, 32'h000000C6, 3, -1, 32'h0);
    run_op("lw_hi",    1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 0, 3, 32'h89ABCDEF);

    // Reset while waiting for a response, then a late response.
    valid_i      = 1'b1;
    is_mem_op_i  = 1'b1;
    is_load_op_i = 1'b1;
    addr_i       = 32'h300;
    @(posedge clk);
    #1;
    idle_inputs();
    req_yumi_i = 1'b1;
    @(posedge clk);
    #1;
    req_yumi_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.stall_before", {31'b0, stall_o}, 32'h1);
    reset = 1'b1;
    #1;
    chk_quiet("rst_mid");
    @(posedge clk);
    #1;
    reset        = 1'b0;
    resp_valid_i = 1'b1;
    resp_data_i  = 32'hFEEDFACE;
    @(negedge clk);
    chk_quiet("late_resp");
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk_quiet("late_resp_after");
    @(posedge clk);
    #1;
    run_op("post_rst", 1'b1, 1'b0, 32'h304, 32'h0, 0, 1, 32'h600DD00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
